vdp_cpu_port: RTL and testbench
===============================

VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 Parameter ADDR_W, default 14, VRAM address width; the address counter wraps modulo 2^ADDR_W.
REQ-002 clk  in  1  system clock, the 28.4 MHz cpuClock domain.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 io_en  in  1  one-cycle strobe marking a CPU I/O cycle edge; all CPU-side inputs are sampled only when it is high.
REQ-005 io_wr, io_rd  in  1 each  decoded CPU write/read to a VDP port, mutually exclusive.
REQ-006 port  in  1  0 = data port (0x98), 1 = control port (0x99).
REQ-007 din  in  8  CPU write data; dout  out  8  CPU read data (combinational: port 0 -> read-ahead latch, port 1 -> status byte).
REQ-008 wait_n  out  1  low while a VRAM operation is pending.
REQ-009 vram_req, vram_we  out  1 each; vram_addr  out  ADDR_W; vram_wdata  out  8  request to the VRAM arbiter.
REQ-010 vram_ack  in  1  grant/complete; vram_rdata  in  8, valid in the ack cycle.
REQ-011 regs  out  64  VDP registers R0..R7, with R(n) at bits [8n+7:8n].
REQ-012 int_set, coll_set, fifth_set  in  1 each; fifth_num  in  5  status event pulses from the video engine.

Function
REQ-013 The first-byte toggle SHALL flip on every accepted control write; the byte written when toggle=0 is latched as first.
REQ-014 Second byte with bit7=1 SHALL write first-byte into R[din[2:0]] only when din[5:3]==0; otherwise it is ignored.
REQ-015 Second byte with bit7=0: addr <= {din[5:0], first}; if din[6]=0 (read setup), the block SHALL issue a prefetch read.
REQ-016 Any accepted port-0 access or port-1 read SHALL clear the toggle to 0.
REQ-017 Data write SHALL copy din into the read-ahead latch, issue a write at addr, and increment addr.
REQ-018 Data read SHALL return the current latch contents, increment addr, and issue a prefetch at the new addr.
REQ-019 FSM states: IDLE, WR (write pending), RD (prefetch pending); IDLE -> WR/RD on the io_en cycle; WR/RD -> IDLE on vram_ack.
REQ-020 vram_req SHALL rise the cycle after triggering io_en and hold addr/we/wdata stable until ack; it SHALL be low the cycle after ack.
REQ-021 In RD, the latch SHALL load vram_rdata in the ack cycle.
REQ-022 wait_n = (state==IDLE).
REQ-023 While not IDLE, every io_en access except a port-1 read SHALL be ignored with no state change (the host retries).
REQ-024 Status byte = {F, 5S, C, fifth_num_latched}; F, C, and 5S are sticky and set by int_set, coll_set, and fifth_set respectively (fifth_set also latches fifth_num).
REQ-025 A port-1 read SHALL clear F, C, and 5S one cycle after the io_en cycle; a set pulse in the same cycle as the clear SHALL win.
REQ-026 Address wrap: increment from 2^ADDR_W-1 SHALL give 0.

Reset
REQ-027 Reset SHALL immediately force: state IDLE, vram_req=0, vram_we=0, wait_n=1, addr=0, latch=0, toggle=0, first=0, all regs=0, status flags=0, fifth_num latch=0.
REQ-028 Reset mid-request SHALL abandon the operation; a vram_ack after reset is ignored.

Verification
REQ-029 Control writes 0x00,0x40 (write setup 0x0000), then data writes 0xAA,0x55 with immediate ack -> VRAM writes at 0x0000=0xAA and 0x0001=0x55; addr=0x0002.
REQ-030 Control writes 0x34,0x12 (read setup 0x1234), ack with rdata 0x77 -> prefetch at 0x1234; the next data read returns 0x77 and prefetches 0x1235.
REQ-031 Control writes 0xF0,0x87 -> R7=0xF0; control writes 0x11,0x8F -> no register change.
REQ-032 Data write while ack is delayed 5 cycles -> wait_n low for those cycles; a second data write during the delay is ignored and no extra VRAM write occurs.
REQ-033 int_set pulse, then port-1 read -> dout bit7=1; the following read gives bit7=0; int_set coincident with the clear cycle -> F remains 1.
REQ-034 Write setup at 0x3FFF plus one data write -> addr wraps to 0x0000; assert reset with vram_req high -> req drops at once and all outputs take their reset values.

Source files
------------

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side I/O port of the VDP.
// Handles data port (0x98) and control port (0x99) accesses: the two-byte
// control sequence (register write or VRAM address setup), data reads and
// writes through a one-byte read-ahead latch, and sticky status flags.
// Ports:
//   clk_i, reset_i (async, active-high)
//   io_en_i, io_wr_i, io_rd_i, port_i, din_i, dout_o   CPU bus side
//   wait_n_o                                           CPU wait (low = busy)
//   vram_req_o, vram_we_o, vram_addr_o, vram_wdata_o,
//   vram_ack_i, vram_rdata_i                           VRAM arbiter side
//   regs_o                                             R0..R7, R(n) at [8n+7:8n]
//   int_set_i, coll_set_i, fifth_set_i, fifth_num_i    status events
module vdp_cpu_port #(
   parameter int ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              io_en_i,
   input  logic              io_wr_i,
   input  logic              io_rd_i,
   input  logic              port_i,
   input  logic [7:0]        din_i,
   output logic [7:0]        dout_o,
   output logic              wait_n_o,
   output logic              vram_req_o,
   output logic              vram_we_o,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic [7:0]        vram_wdata_o,
   input  logic              vram_ack_i,
   input  logic [7:0]        vram_rdata_i,
   output logic [63:0]       regs_o,
   input  logic              int_set_i,
   input  logic              coll_set_i,
   input  logic              fifth_set_i,
   input  logic [4:0]        fifth_num_i
);

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;          // CPU-visible address counter
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;  // address of the pending VRAM op
   logic [7:0]        latch_q, latch_d;        // read-ahead latch, also write data
   logic              toggle_q, toggle_d;
   logic [7:0]        first_q, first_d;
   logic [7:0][7:0]   regs_q, regs_d;
   logic              f_q, f_d, c_q, c_d, s_q, s_d;
   logic [4:0]        fnum_q, fnum_d;
   logic              clr_q, clr_d;            // status clear scheduled for this cycle

   logic [13:0]       setup_addr;
   logic [ADDR_W-1:0] addr_inc;

   assign setup_addr = {din_i[5:0], first_q};
   assign addr_inc   = addr_q + ADDR_W'(1);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      req_addr_d = req_addr_q;
      latch_d    = latch_q;
      toggle_d   = toggle_q;
      first_d    = first_q;
      regs_d     = regs_q;
      // A set pulse coinciding with the delayed clear keeps the flag set.
      f_d        = (f_q & ~clr_q) | int_set_i;
      c_d        = (c_q & ~clr_q) | coll_set_i;
      s_d        = (s_q & ~clr_q) | fifth_set_i;
      fnum_d     = fifth_set_i ? fifth_num_i : fnum_q;
      clr_d      = io_en_i & io_rd_i & port_i;

      case (state_q)
         IDLE: begin
            if (io_en_i) begin
               if (!port_i) begin
                  toggle_d = 1'b0;
                  if (io_wr_i) begin
                     latch_d    = din_i;
                     req_addr_d = addr_q;
                     addr_d     = addr_inc;
                     state_d    = WR;
                  end else if (io_rd_i) begin
                     // Latch already holds the byte for this read; fetch the next one.
                     addr_d     = addr_inc;
                     req_addr_d = addr_inc;
                     state_d    = RD;
                  end
               end else if (io_rd_i) begin
                  toggle_d = 1'b0;
               end else if (io_wr_i) begin
                  if (!toggle_q) begin
                     first_d  = din_i;
                     toggle_d = 1'b1;
                  end else begin
                     toggle_d = 1'b0;
                     if (din_i[7]) begin
                        if (din_i[5:3] == 3'd0) regs_d[din_i[2:0]] = first_q;
                     end else begin
                        addr_d = ADDR_W'(setup_addr);
                        if (!din_i[6]) begin
                           req_addr_d = ADDR_W'(setup_addr);
                           state_d    = RD;
                        end
                     end
                  end
               end
            end
         end
         WR, RD: begin
            // Only status reads get through while busy; everything else is retried.
            if (io_en_i && io_rd_i && port_i) toggle_d = 1'b0;
            if (vram_ack_i) begin
               if (state_q == RD) latch_d = vram_rdata_i;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         req_addr_q <= '0;
         latch_q    <= '0;
         toggle_q   <= 1'b0;
         first_q    <= '0;
         regs_q     <= '0;
         f_q        <= 1'b0;
         c_q        <= 1'b0;
         s_q        <= 1'b0;
         fnum_q     <= '0;
         clr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         req_addr_q <= req_addr_d;
         latch_q    <= latch_d;
         toggle_q   <= toggle_d;
         first_q    <= first_d;
         regs_q     <= regs_d;
         f_q        <= f_d;
         c_q        <= c_d;
         s_q        <= s_d;
         fnum_q     <= fnum_d;
         clr_q      <= clr_d;
      end
   end

   assign wait_n_o     = (state_q == IDLE);
   assign vram_req_o   = (state_q != IDLE);
   assign vram_we_o    = (state_q == WR);
   assign vram_addr_o  = req_addr_q;
   assign vram_wdata_o = latch_q;
   assign regs_o       = regs_q;
   assign dout_o       = port_i ? {f_q, s_q, c_q, fnum_q} : latch_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_vdp_cpu_port;
   logic        clk = 0, rst = 1;
   logic        io_en = 0, io_wr = 0, io_rd = 0, port = 0;
   logic [7:0]  din = 0, dout;
   logic        wait_n, vram_req, vram_we, vram_ack = 0;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata, vram_rdata = 0;
   logic [63:0] regs;
   logic        int_set = 0, coll_set = 0, fifth_set = 0;
   logic [4:0]  fifth_num = 0;

   vdp_cpu_port #(.ADDR_W(14)) dut (
      .clk_i(clk), .reset_i(rst), .io_en_i(io_en), .io_wr_i(io_wr), .io_rd_i(io_rd),
      .port_i(port), .din_i(din), .dout_o(dout), .wait_n_o(wait_n),
      .vram_req_o(vram_req), .vram_we_o(vram_we), .vram_addr_o(vram_addr),
      .vram_wdata_o(vram_wdata), .vram_ack_i(vram_ack), .vram_rdata_i(vram_rdata),
      .regs_o(regs), .int_set_i(int_set), .coll_set_i(coll_set),
      .fifth_set_i(fifth_set), .fifth_num_i(fifth_num));

   always #5 clk = ~clk;

   int tests = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mem [0:16383];
   logic [13:0] m_addr, m_paddr;
   logic [7:0]  m_latch, m_first, m_pdata;
   logic [7:0]  m_regs [0:7];
   logic        m_tog, m_busy, m_pwe, m_F, m_C, m_S, m_clr;
   logic [4:0]  m_fnum;

   function automatic logic [63:0] m_regs_flat();
      logic [63:0] r = 0;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
      return r;
   endfunction

   task automatic m_reset();
      m_addr = 0; m_paddr = 0; m_latch = 0; m_first = 0; m_pdata = 0;
      m_tog = 0; m_busy = 0; m_pwe = 0; m_F = 0; m_C = 0; m_S = 0; m_clr = 0; m_fnum = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
   endtask

   task automatic m_start(input logic we, input logic [13:0] a, input logic [7:0] d);
      m_busy = 1; m_pwe = we; m_paddr = a; m_pdata = d;
   endtask

   task automatic m_step();
      logic was_busy;
      m_F = (m_F && !m_clr) || int_set;
      m_C = (m_C && !m_clr) || coll_set;
      m_S = (m_S && !m_clr) || fifth_set;
      if (fifth_set) m_fnum = fifth_num;
      m_clr = io_en && io_rd && port;
      was_busy = m_busy;
      if (m_busy && vram_ack) begin
         if (!m_pwe) m_latch = vram_rdata;
         m_busy = 0;
      end
      if (io_en) begin
         if (io_rd && port) m_tog = 0;
         else if (!was_busy) begin
            if (!port) begin
               m_tog = 0;
               if (io_wr) begin
                  m_latch = din; m_start(1, m_addr, din); m_addr = m_addr + 1;
               end else if (io_rd) begin
                  m_addr = m_addr + 1; m_start(0, m_addr, 0);
               end
            end else if (io_wr) begin
               if (!m_tog) begin m_first = din; m_tog = 1; end
               else begin
                  m_tog = 0;
                  if (din[7]) begin
                     if (din[5:3] == 0) m_regs[din[2:0]] = m_first;
                  end else begin
                     m_addr = {din[5:0], m_first};
                     if (!din[6]) m_start(0, m_addr, 0);
                  end
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) m_reset(); else m_step();
   end

   // Per-cycle compare against the model.
   logic chk_en = 0;
   initial forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
         check("wait_n", wait_n, !m_busy);
         check("vram_req", vram_req, m_busy);
         if (m_busy) begin
            check("vram_we", vram_we, m_pwe);
            check("vram_addr", vram_addr, m_paddr);
            if (m_pwe) check("vram_wdata", vram_wdata, m_pdata);
         end
         check("regs", regs, m_regs_flat());
         check("dout", dout, port ? {m_F, m_S, m_C, m_fnum} : m_latch);
      end
   end

   // ---------------- VRAM responder ----------------
   logic en_resp = 1, rand_delay = 0, in_req = 0;
   int   ack_delay = 0, cnt = 0, wr_cnt = 0;
   initial forever begin
      @(posedge clk); #1;
      if (rst) begin
         if (en_resp) vram_ack = 0;
         in_req = 0;
      end else if (en_resp) begin
         if (vram_ack) vram_ack = 0;
         else if (vram_req) begin
            if (!in_req) begin
               in_req = 1;
               cnt = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
            end
            if (cnt == 0) begin
               vram_ack = 1; in_req = 0;
               if (vram_we) begin mem[vram_addr] = vram_wdata; wr_cnt++; end
               else vram_rdata = mem[vram_addr];
            end else cnt--;
         end
      end
   end

   // Counts cycles with wait_n low while enabled.
   logic cnt_en = 0;
   int   lowcnt = 0;
   initial forever begin
      @(negedge clk);
      if (cnt_en && !wait_n) lowcnt++;
   end

   // Random status-event pulses.
   logic rand_sets = 0;
   initial forever begin
      @(posedge clk); #1;
      if (rand_sets) begin
         int_set   = ($urandom_range(0, 15) == 0);
         coll_set  = ($urandom_range(0, 15) == 0);
         fifth_set = ($urandom_range(0, 15) == 0);
         fifth_num = 5'($urandom);
      end
   end

   // ---------------- drivers ----------------
   // One io_en cycle; rv is dout as seen during the access.
   task automatic io(input logic p, input logic w, input logic [7:0] d, output logic [7:0] rv);
      io_en = 1; port = p; io_wr = w; io_rd = !w; din = d;
      #1 rv = dout;
      @(posedge clk); #1;
      io_en = 0; io_wr = 0; io_rd = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!wait_n && n < 50) begin @(posedge clk); #1; n++; end
      if (!wait_n) check("wait_idle_timeout", 1, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [7:0] rv;
   int         wr0;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      m_reset();
      idle(2);
      rst = 0;
      chk_en = 1;
      idle(1);
      // Reset state
      check("rst_wait_n", wait_n, 1);
      check("rst_req", vram_req, 0);
      check("rst_regs", regs, 0);
      port = 1; #1 check("rst_status", dout, 0);
      port = 0; #1 check("rst_latch", dout, 0);

      // Write setup 0x0000, two data writes with immediate ack
      ack_delay = 0;
      io(1, 1, 8'h00, rv); io(1, 1, 8'h40, rv);
      io(0, 1, 8'hAA, rv); wait_idle();
      io(0, 1, 8'h55, rv); wait_idle();
      check("mem0", mem[0], 8'hAA);
      check("mem1", mem[1], 8'h55);
      io(0, 1, 8'h11, rv);
      check("addr_after_two", vram_addr, 14'h0002);
      wait_idle();

      // Read setup 0x1234, prefetch then data read
      mem[14'h1234] = 8'h77;
      io(1, 1, 8'h34, rv); io(1, 1, 8'h12, rv);
      check("prefetch_addr", vram_addr, 14'h1234);
      check("prefetch_we", vram_we, 0);
      wait_idle();
      io(0, 0, 8'h00, rv);
      check("read_data", rv, 8'h77);
      check("next_prefetch", vram_addr, 14'h1235);
      wait_idle();

      // Register writes
      io(1, 1, 8'hF0, rv); io(1, 1, 8'h87, rv);
      check("r7_write", regs, 64'hF0 << 56);
      io(1, 1, 8'h11, rv); io(1, 1, 8'h8F, rv);
      check("reg_ignored", regs, 64'hF0 << 56);

      // Delayed ack; second write during the wait is dropped
      ack_delay = 5; wr0 = wr_cnt; lowcnt = 0; cnt_en = 1;
      io(0, 1, 8'h3C, rv);
      check("delayed_addr", vram_addr, 14'h1235);
      io(0, 1, 8'hC3, rv);
      wait_idle(); idle(1); cnt_en = 0;
      check("wait_low_cycles", lowcnt, 6);
      check("one_write", wr_cnt - wr0, 1);
      check("delayed_mem", mem[14'h1235], 8'h3C);
      ack_delay = 0;

      // Status flag read/clear
      int_set = 1; idle(1); int_set = 0;
      io(1, 0, 8'h00, rv); check("F_set", rv[7], 1);
      idle(1);
      io(1, 0, 8'h00, rv); check("F_cleared", rv[7], 0);
      int_set = 1; idle(1); int_set = 0;
      io(1, 0, 8'h00, rv); check("F_set2", rv[7], 1);
      int_set = 1; idle(1); int_set = 0;        // coincides with the clear
      io(1, 0, 8'h00, rv); check("F_set_wins", rv[7], 1);
      idle(1);
      io(1, 0, 8'h00, rv); check("F_cleared2", rv[7], 0);

      // Address wrap
      io(1, 1, 8'hFF, rv); io(1, 1, 8'h7F, rv);
      io(0, 1, 8'h99, rv); check("addr_3fff", vram_addr, 14'h3FFF);
      wait_idle();
      io(0, 1, 8'h66, rv); check("addr_wrap", vram_addr, 14'h0000);
      wait_idle();

      // Reset mid-request
      ack_delay = 10;
      io(0, 1, 8'h5A, rv);
      check("req_before_reset", vram_req, 1);
      rst = 1; m_reset();
      #1;
      check("rst_req_drop", vram_req, 0);
      check("rst_we_drop", vram_we, 0);
      check("rst_wait_n_hi", wait_n, 1);
      check("rst_regs_clear", regs, 0);
      port = 0; #1 check("rst_latch_clear", dout, 0);
      idle(2);
      en_resp = 0; rst = 0; idle(1);
      vram_ack = 1; vram_rdata = 8'hEE; idle(1); vram_ack = 0;
      idle(1);
      check("ack_after_rst_latch", dout, 0);
      check("ack_after_rst_wait", wait_n, 1);
      en_resp = 1; ack_delay = 0;

      // Randomized phase
      rand_delay = 1; rand_sets = 1;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 5))
            0, 1: io(1, 1, 8'($urandom), rv);
            2:    io(0, 1, 8'($urandom), rv);
            3:    io(0, 0, 8'h00, rv);
            4:    io(1, 0, 8'h00, rv);
            default: idle(1);
         endcase
      end
      rand_sets = 0; int_set = 0; coll_set = 0; fifth_set = 0;
      wait_idle(); idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
